ifetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the PC and the combinational, word-indexed instruction memory. It owns the PC, drives the memory word address, and captures {pc, instr} pairs into a small prefetch FIFO. It presents those pairs to the IF/ID stage with a valid/ready handshake. It also handles branch/jump redirects, halt/resume, and address faults.

---
 rtl/ifetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ifetch_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational
// word-indexed memory and queues {pc, instr} pairs for the IF/ID stage.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        busy,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALTED,
    S_FAULT
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic           fault_q, fault_d;
  logic [31:0]    fault_pc_q, fault_pc_d;
  logic [PW-1:0]  hd_q, hd_d;
  logic [PW-1:0]  tl_q, tl_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    fpc_q  [BUF_DEPTH];
  logic [31:0]    fins_q [BUF_DEPTH];

  logic           pop;
  logic           push;
  logic           flush;
  logic           can_push;
  logic           redir_en;
  logic           pc_bad;
  logic           rpc_bad;

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) ||
           ({2'b00, a[31:2]} >= 32'(IMEM_DEPTH));
  endfunction

  assign if_valid  = (cnt_q != '0);
  assign pop       = if_valid && if_ready;
  assign can_push  = (cnt_q < CW'(BUF_DEPTH)) || pop;
  assign redir_en  = redirect_valid &&
                     ((state_q == S_FETCH) || (state_q == S_HALTED));
  assign pc_bad    = bad_addr(pc_q);
  assign rpc_bad   = bad_addr(redirect_pc);

  assign imem_addr = {2'b00, pc_q[31:2]};
  assign if_pc     = if_valid ? fpc_q[hd_q]  : '0;
  assign if_instr  = if_valid ? fins_q[hd_q] : '0;
  assign busy      = (state_q == S_FETCH);
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redir_en) begin
      flush = 1'b1;
      if (rpc_bad) begin
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
        state_d    = S_FAULT;
      end else begin
        pc_d = redirect_pc;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (can_push && pc_bad) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            state_d    = S_FAULT;
          end else if (halt_req) begin
            state_d = S_HALTED;
          end else if (can_push) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
        S_HALTED: begin
          if (start && !halt_req) state_d = S_FETCH;
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A flush discards both the queue and any pop the consumer made.
  always_comb begin
    hd_d  = hd_q;
    tl_d  = tl_q;
    cnt_d = cnt_q;
    if (flush) begin
      hd_d  = '0;
      tl_d  = '0;
      cnt_d = '0;
    end else begin
      if (pop)  hd_d = hd_q + PW'(1);
      if (push) tl_d = tl_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      hd_q       <= '0;
      tl_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      hd_q       <= hd_d;
      tl_q       <= tl_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fpc_q[tl_q]  <= pc_q;
      fins_q[tl_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: vector table plus hand-written
// redirect, fault, reset and end-of-memory sequences.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        busy;
  logic        fault;
  logic [31:0] fault_pc;

  int total;
  int bad;

  logic [31:0] mem [256];

  ifetch_ctrl #(
    .RESET_PC  (32'h0),
    .IMEM_DEPTH(256),
    .BUF_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .halt_req      (halt_req),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .busy          (busy),
    .fault         (fault),
    .fault_pc      (fault_pc)
  );

  assign imem_rdata = (imem_addr < 32'd256) ?
                      mem[imem_addr[7:0]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        st;
    logic        hq;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        eb;
    logic [31:0] ea;
    logic        ef;
  } vec_t;

  vec_t tv [32];

  function automatic vec_t mk(
    input logic rst, input logic st, input logic hq,
    input logic rv, input logic [31:0] rpc, input logic rdy,
    input logic ev, input logic [31:0] epc, input logic eb,
    input logic [31:0] ea, input logic ef);
    vec_t v;
    v.rst = rst; v.st = st; v.hq = hq; v.rv = rv;
    v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc;
    v.eb = eb; v.ea = ea; v.ef = ef;
    return v;
  endfunction

  function automatic logic [31:0] exp_ins(input logic [31:0] pc);
    return mem[pc[9:2]];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic h,
                       input logic v, input logic [31:0] p,
                       input logic rd);
    rst_n = r; start = s; halt_req = h;
    redirect_valid = v; redirect_pc = p; if_ready = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          delivered;
  int          order_err;
  logic [31:0] last_pc;
  logic [31:0] nxt_pc;

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | i;
    mem[0] = 32'h0020_0513;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0025_0233;

    tv[0]  = mk(1,1,0,0,0,1, 0,0,1,0,0);
    tv[1]  = mk(1,0,0,0,0,1, 1,32'h0,1,1,0);
    tv[2]  = mk(1,0,0,0,0,1, 1,32'h4,1,2,0);
    tv[3]  = mk(1,0,0,0,0,1, 1,32'h8,1,3,0);
    tv[4]  = mk(0,0,0,0,0,1, 0,0,0,0,0);
    tv[5]  = mk(1,1,0,0,0,0, 0,0,1,0,0);
    tv[6]  = mk(1,0,0,0,0,0, 1,32'h0,1,1,0);
    tv[7]  = mk(1,0,0,0,0,0, 1,32'h0,1,2,0);
    tv[8]  = mk(1,0,0,0,0,0, 1,32'h0,1,2,0);
    tv[9]  = mk(1,0,0,0,0,0, 1,32'h0,1,2,0);
    tv[10] = mk(1,0,0,0,0,0, 1,32'h0,1,2,0);
    tv[11] = mk(1,0,0,0,0,1, 1,32'h4,1,3,0);
    tv[12] = mk(1,0,0,0,0,1, 1,32'h8,1,4,0);
    tv[13] = mk(1,0,0,0,0,1, 1,32'hC,1,5,0);
    tv[14] = mk(0,0,0,0,0,1, 0,0,0,0,0);
    tv[15] = mk(1,1,0,0,0,1, 0,0,1,0,0);
    tv[16] = mk(1,0,0,0,0,1, 1,32'h0,1,1,0);
    tv[17] = mk(1,0,0,0,0,1, 1,32'h4,1,2,0);
    tv[18] = mk(1,0,0,0,0,1, 1,32'h8,1,3,0);
    tv[19] = mk(1,0,1,0,0,0, 1,32'h8,0,3,0);
    tv[20] = mk(1,0,1,0,0,1, 0,0,0,3,0);
    tv[21] = mk(1,0,1,0,0,1, 0,0,0,3,0);
    tv[22] = mk(1,1,0,0,0,1, 0,0,1,3,0);
    tv[23] = mk(1,0,0,0,0,1, 1,32'hC,1,4,0);
    tv[24] = mk(1,0,1,0,0,0, 1,32'hC,0,4,0);
    tv[25] = mk(1,0,1,1,32'h20,0, 0,0,0,8,0);
    tv[26] = mk(1,1,0,0,0,0, 0,0,1,8,0);
    tv[27] = mk(1,0,0,0,0,1, 1,32'h20,1,9,0);
    tv[28] = mk(0,0,0,0,0,0, 0,0,0,0,0);
    tv[29] = mk(1,1,1,0,0,0, 0,0,1,0,0);
    tv[30] = mk(1,0,1,0,0,0, 0,0,0,0,0);
    tv[31] = mk(1,0,1,0,0,1, 0,0,0,0,0);

    drive(0,0,0,0,0,0);
    tick();
    tick();
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    for (int i = 0; i < 32; i++) begin
      drive(tv[i].rst, tv[i].st, tv[i].hq,
            tv[i].rv, tv[i].rpc, tv[i].rdy);
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, if_valid},
          {31'b0, tv[i].ev});
      chk($sformatf("v%0d_pc", i), if_pc,
          tv[i].ev ? tv[i].epc : 32'h0);
      chk($sformatf("v%0d_instr", i), if_instr,
          tv[i].ev ? exp_ins(tv[i].epc) : 32'h0);
      chk($sformatf("v%0d_busy", i), {31'b0, busy},
          {31'b0, tv[i].eb});
      chk($sformatf("v%0d_addr", i), imem_addr, tv[i].ea);
      chk($sformatf("v%0d_fault", i), {31'b0, fault},
          {31'b0, tv[i].ef});
    end

    // Redirect with full queue and a pop offered the same cycle
    drive(0,0,0,0,0,0); tick();
    drive(1,1,0,0,0,0); tick();
    drive(1,0,0,0,0,0); tick(); tick();
    chk("full_pc", if_pc, 32'h0);
    chk("full_addr", imem_addr, 32'h2);
    drive(1,0,0,1,32'h10,1); tick();
    chk("redir_flush", {31'b0, if_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h4);
    drive(1,0,0,0,0,1); tick();
    chk("redir_valid", {31'b0, if_valid}, 32'd1);
    chk("redir_pc", if_pc, 32'h10);
    chk("redir_instr", if_instr, exp_ins(32'h10));
    tick();
    chk("redir_next", if_pc, 32'h14);

    // Misaligned redirect faults and sticks until reset
    drive(1,0,0,1,32'h6,1); tick();
    chk("flt_fault", {31'b0, fault}, 32'd1);
    chk("flt_pc", fault_pc, 32'h6);
    chk("flt_valid", {31'b0, if_valid}, 32'd0);
    chk("flt_busy", {31'b0, busy}, 32'd0);
    drive(1,1,0,0,0,1); tick();
    drive(1,0,0,1,32'h40,1); tick();
    drive(1,0,0,0,0,1); tick();
    chk("flt_sticky", {31'b0, fault}, 32'd1);
    chk("flt_sticky_pc", fault_pc, 32'h6);
    chk("flt_no_fetch", {31'b0, if_valid | busy}, 32'd0);
    drive(0,0,0,0,0,1); tick();
    chk("flt_clr", {31'b0, fault}, 32'd0);
    chk("flt_clr_pc", fault_pc, 32'h0);

    // Reset with a full queue
    drive(1,1,0,0,0,0); tick();
    drive(1,0,0,0,0,0); tick(); tick();
    chk("mid_full", {31'b0, if_valid}, 32'd1);
    drive(0,0,0,0,0,1); tick();
    chk("mid_valid", {31'b0, if_valid}, 32'd0);
    chk("mid_fault", {31'b0, fault}, 32'd0);
    chk("mid_addr", imem_addr, 32'h0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    drive(1,0,0,0,0,1); tick();
    chk("mid_idle", {31'b0, if_valid | busy}, 32'd0);

    // Sequential run off the end of memory
    delivered = 0;
    order_err = 0;
    last_pc   = 32'hFFFF_FFFF;
    nxt_pc    = 32'h0;
    drive(1,1,0,0,0,1); tick();
    drive(1,0,0,0,0,1);
    for (int c = 0; c < 400; c++) begin
      tick();
      if (if_valid) begin
        if (if_pc !== nxt_pc || if_instr !== exp_ins(nxt_pc))
          order_err++;
        last_pc = if_pc;
        nxt_pc  = if_pc + 32'd4;
        delivered++;
      end
      if (fault && !if_valid) break;
    end
    chk("run_fault", {31'b0, fault}, 32'd1);
    chk("run_fault_pc", fault_pc, 32'h400);
    chk("run_last", last_pc, 32'h3FC);
    chk("run_count", delivered, 32'd256);
    chk("run_order", order_err, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
